// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: source selects, load types, FSM states.
package wb_pkg;

    typedef enum logic [2:0] {
        WB_ALU    = 3'b000,
        WB_MEM    = 3'b001,
        WB_PC_IMM = 3'b010,
        WB_IMM    = 3'b011,
        WB_PC4    = 3'b101
    } wb_sel_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_f3_e;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    // True for the five load encodings the stage understands.
    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            LB, LH, LW, LBU, LHU: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Sub-word lane extraction and sign/zero extension of a load word,
// plus the alignment check for the requested access size.
module load_extend #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    import wb_pkg::*;

    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] w_lane;

    // Pick the addressed lane and extend it to the full datapath width.
    always_comb begin
        b_lane   = rdata[{off, 3'b000} +: 8];
        h_lane   = rdata[{off[1], 4'b0000} +: 16];
        w_lane   = rdata[31:0];
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            LB:  data = XLEN'($signed(b_lane));
            LBU: data = XLEN'(b_lane);
            LH: begin
                data     = XLEN'($signed(h_lane));
                misalign = off[0];
            end
            LHU: begin
                data     = XLEN'(h_lane);
                misalign = off[0];
            end
            LW: begin
                data     = XLEN'($signed(w_lane));
                misalign = (off != 2'b00);
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage. Non-load results are written one cycle after
// acceptance; loads wait in LOAD_WAIT for mem_rvalid, bounded by a timeout.
// Handshake: a request transfers on a cycle where in_valid && in_ready;
// in_ready is high only in IDLE, so a pending load stalls the front end.
module wb_stage #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_off,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   pc_imm,
    input  logic [XLEN-1:0]   pc_4,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy,
    output logic              err_misalign,
    output logic              err_timeout,
    output logic              err_sel,
    output logic              dbg_state
);
    import wb_pkg::*;

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    wb_state_e         state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [REG_AW-1:0] ld_rd, ld_rd_d;
    logic [2:0]        ld_f3, ld_f3_d;
    logic [1:0]        ld_off, ld_off_d;
    logic              we_d, emis_d, eto_d, esel_d;
    logic [REG_AW-1:0] waddr_d;
    logic [XLEN-1:0]   wdata_d;

    logic [2:0]        ext_f3;
    logic [1:0]        ext_off;
    logic [XLEN-1:0]   ext_data;
    logic              ext_mis;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == LOAD_WAIT);
    assign dbg_state = state;

    // In IDLE the extender checks the incoming request; while waiting it
    // formats the response using the latched load attributes.
    assign ext_f3  = (state == IDLE) ? in_funct3 : ld_f3;
    assign ext_off = (state == IDLE) ? in_off    : ld_off;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata    (mem_rdata),
        .funct3   (ext_f3),
        .off      (ext_off),
        .data     (ext_data),
        .misalign (ext_mis)
    );

    // Next-state and next-output decode; writes to x0 are suppressed.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ld_rd_d  = ld_rd;
        ld_f3_d  = ld_f3;
        ld_off_d = ld_off;
        we_d     = 1'b0;
        waddr_d  = rf_waddr;
        wdata_d  = rf_wdata;
        emis_d   = 1'b0;
        eto_d    = 1'b0;
        esel_d   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_sel)
                        WB_ALU, WB_PC_IMM, WB_IMM, WB_PC4: begin
                            if (in_rd != '0) begin
                                we_d    = 1'b1;
                                waddr_d = in_rd;
                                case (in_sel)
                                    WB_PC_IMM: wdata_d = pc_imm;
                                    WB_IMM:    wdata_d = imm;
                                    WB_PC4:    wdata_d = pc_4;
                                    default:   wdata_d = alu_out;
                                endcase
                            end
                        end
                        WB_MEM: begin
                            if (!f3_legal(in_funct3)) begin
                                esel_d = 1'b1;
                            end else if (ext_mis) begin
                                emis_d = 1'b1;
                            end else begin
                                state_d  = LOAD_WAIT;
                                cnt_d    = '0;
                                ld_rd_d  = in_rd;
                                ld_f3_d  = in_funct3;
                                ld_off_d = in_off;
                            end
                        end
                        default: esel_d = 1'b1;
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (ld_rd != '0) begin
                        we_d    = 1'b1;
                        waddr_d = ld_rd;
                        wdata_d = ext_data;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    eto_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched load attributes and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_rd        <= '0;
            ld_f3        <= '0;
            ld_off       <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            err_sel      <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            ld_rd        <= ld_rd_d;
            ld_f3        <= ld_f3_d;
            ld_off       <= ld_off_d;
            rf_we        <= we_d;
            rf_waddr     <= waddr_d;
            rf_wdata     <= wdata_d;
            err_misalign <= emis_d;
            err_timeout  <= eto_d;
            err_sel      <= esel_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_wb_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int TMO  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_sel = '0;
    logic [AW-1:0]   in_rd = '0;
    logic [2:0]      in_funct3 = '0;
    logic [1:0]      in_off = '0;
    logic [XLEN-1:0] alu_out = '0, pc_imm = '0, pc_4 = '0, imm = '0, mem_rdata = '0;
    logic            mem_rvalid = 1'b0;
    logic            rf_we, busy, err_misalign, err_timeout, err_sel, dbg_state;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    wb_stage #(.XLEN(XLEN), .REG_AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_funct3(in_funct3), .in_off(in_off),
        .alu_out(alu_out), .pc_imm(pc_imm), .pc_4(pc_4), .imm(imm),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy),
        .err_misalign(err_misalign), .err_timeout(err_timeout), .err_sel(err_sel),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit            pending;
        int            waited;
        logic [AW-1:0] rd;
        logic [2:0]    f3;
        logic [1:0]    off;
        bit            we;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
        bit            emis, eto, esel;
    } mstate_t;

    mstate_t m = '{default: 0};
    mstate_t m_next;
    logic [AW+XLEN-1:0] exp_q[$];

    function automatic logic [31:0] m_extend(logic [31:0] word, logic [2:0] f3, logic [1:0] off);
        longint w, v;
        w = longint'({32'b0, word});
        v = 0;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * off)) & 255;
                if (f3 == 3'd0 && v > 127) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (off / 2))) & 65535;
                if (f3 == 3'd1 && v > 32767) v = v - 65536;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    function automatic mstate_t m_step(mstate_t s);
        mstate_t n = s;
        n.we = 0; n.emis = 0; n.eto = 0; n.esel = 0;
        if (!s.pending) begin
            if (in_valid) begin
                if (in_sel == 3'd1) begin
                    if (!(in_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) n.esel = 1;
                    else if ((in_funct3 inside {3'd1, 3'd5} && (in_off % 2) == 1) ||
                             (in_funct3 == 3'd2 && in_off != 0)) n.emis = 1;
                    else begin
                        n.pending = 1; n.waited = 0;
                        n.rd = in_rd; n.f3 = in_funct3; n.off = in_off;
                    end
                end else if (in_sel inside {3'd0, 3'd2, 3'd3, 3'd5}) begin
                    if (in_rd != 0) begin
                        n.we = 1; n.waddr = in_rd;
                        n.wdata = (in_sel == 3'd0) ? alu_out : (in_sel == 3'd2) ? pc_imm :
                                  (in_sel == 3'd3) ? imm : pc_4;
                    end
                end else n.esel = 1;
            end
        end else if (mem_rvalid) begin
            n.pending = 0;
            if (s.rd != 0) begin
                n.we = 1; n.waddr = s.rd; n.wdata = m_extend(mem_rdata, s.f3, s.off);
            end
        end else begin
            n.waited = s.waited + 1;
            if (n.waited == TMO) begin
                n.pending = 0; n.eto = 1;
            end
        end
        return n;
    endfunction

    always_comb m_next = m_step(m);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m <= '{default: 0};
            exp_q.delete();
        end else begin
            m <= m_next;
            if (m_next.we) exp_q.push_back({m_next.waddr, m_next.wdata});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rstn) begin
            chk("in_ready", in_ready, !m.pending);
            chk("busy", busy, m.pending);
            chk("dbg_state", dbg_state, m.pending);
            chk("rf_we", rf_we, m.we);
            chk("rf_waddr", rf_waddr, m.waddr);
            chk("rf_wdata", rf_wdata, m.wdata);
            chk("err_misalign", err_misalign, m.emis);
            chk("err_timeout", err_timeout, m.eto);
            chk("err_sel", err_sel, m.esel);
            if (rf_we) begin
                chk("wr_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("wr_q", {rf_waddr, rf_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [2:0] sel, input logic [AW-1:0] rd,
                       input logic [2:0] f3, input logic [1:0] off);
        in_valid = 1'b1; in_sel = sel; in_rd = rd; in_funct3 = f3; in_off = off;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [AW-1:0] rd,
                           input logic [31:0] data, input int delay, input logic [31:0] exp);
        req(3'd1, rd, f3, off);
        cyc();
        idle();
        chk("ld_busy", busy, 1);
        chk("ld_in_ready", in_ready, 0);
        repeat (delay - 1) cyc();
        chk("ld_busy_hold", busy, 1);
        mem_rvalid = 1'b1; mem_rdata = data;
        cyc();
        mem_rvalid = 1'b0;
        chk("ld_we", rf_we, 1);
        chk("ld_data", rf_wdata, exp);
        chk("ld_busy_done", busy, 0);
    endtask

    initial begin
        int seen;
        logic [2:0] sel_tab [10];
        sel_tab = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7, 3'd1};

        // Reset state
        #3;
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_misalign, err_timeout, err_sel}, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        chk("rst_ready", in_ready, 1);

        // Back-to-back ALU then IMM, then rd=0
        alu_out = 32'h12345678; imm = 32'hABCDE000;
        req(3'd0, 5'd5, 3'd0, 2'd0);
        cyc();
        req(3'd3, 5'd6, 3'd0, 2'd0);
        chk("alu_we", rf_we, 1);
        chk("alu_addr", rf_waddr, 5);
        chk("alu_data", rf_wdata, 32'h12345678);
        cyc();
        req(3'd0, 5'd0, 3'd0, 2'd0);
        chk("imm_we", rf_we, 1);
        chk("imm_addr", rf_waddr, 6);
        chk("imm_data", rf_wdata, 32'hABCDE000);
        cyc();
        idle();
        chk("x0_we", rf_we, 0);
        chk("x0_hold", rf_waddr, 6);

        // Loads: LB / LBU off=3 with 3-cycle delay, LHU off=2
        do_load(3'd0, 2'd3, 5'd7, 32'h80FF0000, 3, 32'hFFFFFF80);
        do_load(3'd4, 2'd3, 5'd8, 32'h80FF0000, 3, 32'h00000080);
        do_load(3'd5, 2'd2, 5'd9, 32'hBEEF1234, 1, 32'h0000BEEF);

        // Misaligned LH
        req(3'd1, 5'd4, 3'd1, 2'd1);
        cyc();
        idle();
        chk("mis_pulse", err_misalign, 1);
        chk("mis_we", rf_we, 0);
        chk("mis_busy", busy, 0);
        cyc();
        chk("mis_clear", err_misalign, 0);

        // Timeout, then stray rvalid
        req(3'd1, 5'd10, 3'd2, 2'd0);
        cyc();
        idle();
        seen = 0;
        for (int k = 1; k <= TMO + 4; k++) begin
            cyc();
            if (err_timeout && seen == 0) seen = k;
        end
        chk("timeout_cycle", seen, TMO);
        chk("timeout_ready", in_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        cyc();
        mem_rvalid = 1'b0;
        chk("stray_we", rf_we, 0);

        // Illegal select and illegal load type
        req(3'd7, 5'd3, 3'd0, 2'd0);
        cyc();
        req(3'd1, 5'd3, 3'd3, 2'd0);
        chk("sel7_err", err_sel, 1);
        chk("sel7_we", rf_we, 0);
        cyc();
        idle();
        chk("f3_err", err_sel, 1);
        chk("f3_busy", busy, 0);

        // rvalid on the final timeout cycle wins
        req(3'd1, 5'd11, 3'd2, 2'd0);
        cyc();
        idle();
        repeat (TMO - 1) cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        cyc();
        mem_rvalid = 1'b0;
        chk("last_we", rf_we, 1);
        chk("last_data", rf_wdata, 32'hCAFEF00D);
        chk("last_no_to", err_timeout, 0);

        // Reset mid-load
        req(3'd1, 5'd12, 3'd2, 2'd0);
        cyc();
        idle();
        cyc();
        rstn = 1'b0;
        #1;
        chk("amid_busy", busy, 0);
        chk("amid_addr", rf_waddr, 0);
        chk("amid_data", rf_wdata, 0);
        chk("amid_ready", in_ready, 1);
        cyc();
        rstn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        cyc();
        mem_rvalid = 1'b0;
        chk("amid_stray_we", rf_we, 0);

        // Randomized traffic, two response-rate regimes
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 600; i++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_sel    = sel_tab[$urandom_range(0, 9)];
                in_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                in_funct3 = 3'($urandom_range(0, 7));
                in_off    = 2'($urandom_range(0, 3));
                alu_out   = $urandom; pc_imm = $urandom; pc_4 = $urandom; imm = $urandom;
                mem_rdata = $urandom;
                mem_rvalid = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
                cyc();
            end
        end
        idle();
        mem_rvalid = 1'b0;
        repeat (TMO + 3) cyc();
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered, parametrised successor to the combinational writeback selector.
- Selects the register-file write value from ALU, load data, PC+imm, imm or PC+4.
- Load data arrives via a variable-latency memory response.
- Adds sub-word load extraction and sign/zero extension, a load-wait state machine with timeout, misalignment detection, and an x0 write-suppression rule.
- Sits between execute/memory and the register file; raises busy so the front end stalls.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- REG_AW, 5, register address width.
- TIMEOUT_CYC, 64, maximum cycles to wait for mem_rvalid; must be >= 2.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  writeback request valid
- in_ready  output  1  stage can accept a request
- in_sel  input  3  source select: 000 ALU, 001 MEM, 010 PC_IMM, 011 IMM, 101 PC_4
- in_rd  input  REG_AW  destination register
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_off  input  2  byte offset of load address
- alu_out, pc_imm, pc_4, imm  input  XLEN each  candidate sources
- mem_rdata  input  XLEN  aligned memory read word
- mem_rvalid  input  1  read data valid (single-cycle pulse)
- rf_we  output  1  register-file write enable (pulse)
- rf_waddr  output  REG_AW  write address
- rf_wdata  output  XLEN  write data
- busy  output  1  load outstanding
- err_misalign  output  1  one-cycle pulse: misaligned load dropped
- err_timeout  output  1  one-cycle pulse: load response timed out
- err_sel  output  1  one-cycle pulse: illegal in_sel dropped

Behaviour:
- Reset (async, rstn low): state=IDLE; rf_we, rf_waddr, rf_wdata, busy, all err_* = 0; timeout counter = 0. Reset mid-load abandons the load; a later mem_rvalid is ignored.
- in_ready = (state==IDLE). A handshake occurs when in_valid && in_ready.
- States: IDLE, LOAD_WAIT.
- IDLE, non-MEM legal sel accepted: next cycle rf_we=1, rf_waddr=in_rd, rf_wdata=selected source. Latency is 1 cycle; back-to-back acceptance each cycle is allowed.
- IDLE, MEM accepted:
  - Misalignment check first: LH/LHU with off[0]=1 or LW with off!=0 -> err_misalign pulse next cycle, no write, stay IDLE.
  - Otherwise latch rd/funct3/off, go to LOAD_WAIT, busy=1, counter=0.
- Illegal sel (100, 110, 111) or illegal funct3 on MEM: err_sel pulse next cycle, no write, stay IDLE.
- LOAD_WAIT:
  - mem_rvalid is sampled only here; it is ignored in IDLE.
  - On mem_rvalid: next cycle rf_we=1 with extended data, state=IDLE, busy=0.
  - Else counter++. When counter reaches TIMEOUT_CYC-1 without rvalid: err_timeout pulse, no write, go to IDLE.
  - If rvalid coincides with the final count, rvalid wins.
- Extension: byte lane = mem_rdata[8*off +: 8]; half lane = mem_rdata[16*off[1] +: 16]. LB/LH sign-extend to XLEN, LBU/LHU zero-extend, LW passes bits [31:0], sign-extended when XLEN=64.
- x0 rule: rd==0 -> rf_we stays 0. The error pulses and the FSM still advance normally.
- rf_waddr/rf_wdata hold their last value when rf_we=0.

Decomposition:
- wb_pkg:
  - wb_sel_e enum (WB_ALU=3'b000, WB_MEM=3'b001, WB_PC_IMM=3'b010, WB_IMM=3'b011, WB_PC4=3'b101).
  - ld_f3_e enum (LB, LH, LW, LBU, LHU).
  - wb_state_e {IDLE, LOAD_WAIT}.
- Sub-module load_extend (combinational): inputs rdata, funct3, off; outputs extended data and misalign flag. Parametrised by XLEN.

Test Plan:
- Reset pulse mid-stream -> all outputs 0 asynchronously, in_ready=1 after release.
- Back-to-back ALU (rd=5, 0x12345678) then IMM (rd=6, 0xABCDE000) on consecutive cycles -> rf_we pulses on cycles 1 and 2 with matching address/data; rd=0 request -> no write.
- LB off=3, mem_rdata=0x80FF_0000 after 3-cycle delay -> busy 3 cycles, in_ready=0, write 0xFFFFFF80. Same with LBU -> 0x00000080.
- LH off=1 -> err_misalign pulse, no write, no busy. LHU off=2 with rdata=0xBEEF_1234 -> 0x0000BEEF.
- Load with no mem_rvalid -> err_timeout exactly TIMEOUT_CYC cycles after acceptance, return to IDLE. A later stray mem_rvalid -> no write.
- sel=3'b111 -> err_sel pulse, no write. mem_rvalid on the last timeout cycle -> write occurs, no err_timeout.
